// File: rtl/chirp_gen_multi.sv
// N-channel LoRa-style linear chirp generator: per-channel phase accumulators
// fed from UART-written shadow registers, all paced by one shared divider tick.
module chirp_gen_multi #(
    parameter int N_CH        = 2,
    parameter int PHASE_WIDTH = 16,
    parameter int OUT_WIDTH   = 8,
    parameter int SF_MIN      = 5,
    parameter int SF_MAX      = 12,
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_cfg_we,
    input  logic [ADDR_WIDTH-1:0]       i_cfg_addr,
    input  logic [DATA_WIDTH-1:0]       i_cfg_data,
    input  logic [N_CH-1:0]             i_start,
    input  logic [N_CH-1:0]             i_stop,
    output logic [N_CH-1:0]             o_busy,
    output logic [N_CH-1:0]             o_valid,
    output logic [N_CH*OUT_WIDTH-1:0]   o_data,
    output logic [N_CH-1:0]             o_done
);
    localparam int PW  = PHASE_WIDTH;
    localparam int SFW = $clog2(SF_MAX + 1);

    typedef enum logic {IDLE, RUN} state_e;

    logic [DATA_WIDTH-1:0] div_q, cnt_q, cnt_d;
    logic                  tick;
    logic [SFW-1:0]        sf_wr;

    always_comb begin
        if (i_cfg_data < DATA_WIDTH'(SF_MIN))      sf_wr = SFW'(SF_MIN);
        else if (i_cfg_data > DATA_WIDTH'(SF_MAX)) sf_wr = SFW'(SF_MAX);
        else                                       sf_wr = SFW'(i_cfg_data);
    end

    // >= rather than == so a lowered DIV can never leave the counter above it
    assign tick  = (cnt_q >= div_q);
    assign cnt_d = tick ? '0 : cnt_q + DATA_WIDTH'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (i_cfg_we && i_cfg_addr == ADDR_WIDTH'(N_CH * 4))
                div_q <= i_cfg_data;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_e          state_q, state_d;
        logic [SFW-1:0]  sf_sh_q, sf_q, sf_d;
        logic [15:0]     sym_sh_q;
        logic [1:0]      ctrl_sh_q, ctrl_q, ctrl_d;
        logic [PW-1:0]   sym_q, sym_d, phase_q, phase_d, n_q, n_d;
        logic [PW-1:0]   mask, sh_mask, k;
        logic [OUT_WIDTH-1:0] data_q, data_d;
        logic            valid_q, valid_d, done_q, done_d;
        logic            last, launch, step, capture;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                sf_sh_q   <= SFW'(SF_MIN);
                sym_sh_q  <= '0;
                ctrl_sh_q <= '0;
            end else if (i_cfg_we) begin
                if (i_cfg_addr == ADDR_WIDTH'(c * 4 + 0)) sf_sh_q        <= sf_wr;
                if (i_cfg_addr == ADDR_WIDTH'(c * 4 + 1)) sym_sh_q[7:0]  <= 8'(i_cfg_data);
                if (i_cfg_addr == ADDR_WIDTH'(c * 4 + 2)) sym_sh_q[15:8] <= 8'(i_cfg_data);
                if (i_cfg_addr == ADDR_WIDTH'(c * 4 + 3)) ctrl_sh_q      <= i_cfg_data[1:0];
            end
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                state_q <= IDLE;
                sf_q    <= SFW'(SF_MIN);
                sym_q   <= '0;
                ctrl_q  <= '0;
                phase_q <= '0;
                n_q     <= '0;
                data_q  <= '0;
                valid_q <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                sf_q    <= sf_d;
                sym_q   <= sym_d;
                ctrl_q  <= ctrl_d;
                phase_q <= phase_d;
                n_q     <= n_d;
                data_q  <= data_d;
                valid_q <= valid_d;
                done_q  <= done_d;
            end
        end

        always_comb begin
            mask    = (PW'(1) << sf_q) - PW'(1);
            sh_mask = (PW'(1) << sf_sh_q) - PW'(1);
            k       = ctrl_q[0] ? ((sym_q - n_q) & mask) : ((sym_q + n_q) & mask);
            last    = (n_q == mask);
            launch  = (state_q == IDLE) && i_start[c] && !i_stop[c];
            step    = (state_q == RUN) && !i_stop[c] && tick;
            capture = launch || (step && last && ctrl_q[1]);
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                IDLE:    if (launch) state_d = RUN;
                RUN:     if (i_stop[c] || (step && last && !ctrl_q[1])) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Phase is deliberately untouched on a repeat capture so back-to-back chirps stay continuous
        always_comb begin
            sf_d    = sf_q;
            sym_d   = sym_q;
            ctrl_d  = ctrl_q;
            phase_d = phase_q;
            n_d     = n_q;
            data_d  = data_q;
            valid_d = 1'b0;
            done_d  = 1'b0;
            if (launch) begin
                phase_d = '0;
                n_d     = '0;
            end
            if (step) begin
                data_d  = phase_q[PW-1 -: OUT_WIDTH];
                phase_d = phase_q + (k << (PW - int'(sf_q)));
                n_d     = last ? '0 : n_q + PW'(1);
                valid_d = 1'b1;
                done_d  = last;
            end
            if (capture) begin
                sf_d   = sf_sh_q;
                ctrl_d = ctrl_sh_q;
                sym_d  = PW'(sym_sh_q) & sh_mask;
            end
        end

        assign o_busy[c]                           = (state_q == RUN);
        assign o_valid[c]                          = valid_q;
        assign o_done[c]                           = done_q;
        assign o_data[c*OUT_WIDTH +: OUT_WIDTH]    = data_q;
    end

endmodule

// File: tb/tb_chirp_gen_multi.sv
// Self-checking bench for chirp_gen_multi: vector table, corner sequences and
// randomized dual-channel chirps against a phase-arithmetic reference model.
`timescale 1ns/1ps
module tb_chirp_gen_multi;
    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic [1:0]  start, stop;
    logic [1:0]  busy, valid, done;
    logic [15:0] data;

    always #5 clk = ~clk;

    chirp_gen_multi #(
        .N_CH(2), .PHASE_WIDTH(16), .OUT_WIDTH(8), .SF_MIN(5), .SF_MAX(12),
        .ADDR_WIDTH(6), .DATA_WIDTH(8)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr),
        .i_cfg_data(cfg_data), .i_start(start), .i_stop(stop),
        .o_busy(busy), .o_valid(valid), .o_data(data), .o_done(done)
    );

    typedef struct {int ch; int data; bit done; int cyc;} rec_t;
    typedef struct {int ch; int sf; int sym; int ctrl; int e0; int e1; int e2; int len;} vec_t;

    rec_t mq[$];
    int   cyc = 0;
    int   spur_done = 0;
    int   n_assert = 0, n_fail = 0;
    int   exp_d[$];
    bit   exp_dn[$];
    int   mphase;

    always @(negedge clk) begin
        cyc++;
        for (int c = 0; c < 2; c++) begin
            if (valid[c]) mq.push_back('{ch: c, data: int'(data[c*8 +: 8]), done: done[c], cyc: cyc});
            if (done[c] && !valid[c]) spur_done++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, int got, int exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int clamp_sf(int v);
        if (v < 5) return 5;
        if (v > 12) return 12;
        return v;
    endfunction

    // Reference: k walks (sym +/- n) mod 2^sf, phase accumulates k*2^(16-sf), output = phase/256
    task automatic model_chirp(int sf, int sym_raw, bit down);
        int len, sym, k;
        len = 1 << sf;
        sym = sym_raw % len;
        for (int n = 0; n < len; n++) begin
            exp_d.push_back((mphase / 256) % 256);
            exp_dn.push_back(n == len - 1);
            k = down ? (((sym - n) % len) + len) % len : (sym + n) % len;
            mphase = (mphase + k * (1 << (16 - sf))) % 65536;
        end
    endtask

    task automatic model_reset();
        exp_d.delete();
        exp_dn.delete();
        mphase = 0;
    endtask

    task automatic cfg_write(int addr, int val);
        cfg_we   = 1'b1;
        cfg_addr = 6'(addr);
        cfg_data = 8'(val);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic config_ch(int ch, int sf, int sym, int ctrl);
        cfg_write(ch * 4 + 0, sf);
        cfg_write(ch * 4 + 1, sym % 256);
        cfg_write(ch * 4 + 2, (sym / 256) % 256);
        cfg_write(ch * 4 + 3, ctrl);
    endtask

    task automatic start_pulse(int m);
        start = 2'(m);
        @(negedge clk);
        start = '0;
    endtask

    task automatic wait_idle(int ch, int budget, string name);
        int t = 0;
        while (busy[ch] && t < budget) begin
            @(negedge clk);
            t++;
        end
        check({name, " finishes within budget"}, int'(busy[ch]), 0);
    endtask

    task automatic wait_valids(int ch, int n, int budget, string name);
        int cnt = 0, t = 0;
        while (cnt < n && t < budget) begin
            @(negedge clk);
            if (valid[ch]) cnt++;
            t++;
        end
        check({name, " valids seen before timeout"}, cnt, n);
    endtask

    function automatic int rec_count(int ch, bit only_done);
        int r = 0;
        foreach (mq[i]) if (mq[i].ch == ch && (!only_done || mq[i].done)) r++;
        return r;
    endfunction

    function automatic int rec_data(int ch, int idx);
        int r = 0;
        foreach (mq[i]) if (mq[i].ch == ch) begin
            if (r == idx) return mq[i].data;
            r++;
        end
        return -1;
    endfunction

    task automatic verify(int ch, string name, int period);
        int gd[$];
        bit gn[$];
        int gc[$];
        int dbad = 0, nbad = 0, pbad = 0;
        foreach (mq[i]) if (mq[i].ch == ch) begin
            gd.push_back(mq[i].data);
            gn.push_back(mq[i].done);
            gc.push_back(mq[i].cyc);
        end
        check({name, " sample count"}, gd.size(), exp_d.size());
        for (int i = 0; i < gd.size() && i < exp_d.size(); i++) begin
            if (gd[i] != exp_d[i]) dbad++;
            if (gn[i] != exp_dn[i]) nbad++;
            if (period > 0 && i > 0 && gc[i] - gc[i-1] != period) pbad++;
        end
        check({name, " data mismatches"}, dbad, 0);
        check({name, " done mismatches"}, nbad, 0);
        if (period > 0) check({name, " period violations"}, pbad, 0);
    endtask

    vec_t tbl[6];

    initial begin
        int rsf[2], rsym[2], rdn[2], m, gaps[$], bad, prev;
        string nm;

        tbl[0] = '{ch: 0, sf: 5,  sym: 0,      ctrl: 0, e0: 0, e1: 0,  e2: 8,   len: 32};
        tbl[1] = '{ch: 1, sf: 5,  sym: 0,      ctrl: 1, e0: 0, e1: 0,  e2: 248, len: 32};
        tbl[2] = '{ch: 1, sf: 5,  sym: 3,      ctrl: 0, e0: 0, e1: 24, e2: 56,  len: 32};
        tbl[3] = '{ch: 0, sf: 2,  sym: 0,      ctrl: 0, e0: 0, e1: 0,  e2: 8,   len: 32};
        tbl[4] = '{ch: 0, sf: 5,  sym: 'h0123, ctrl: 0, e0: 0, e1: 24, e2: 56,  len: 32};
        tbl[5] = '{ch: 1, sf: 15, sym: 0,      ctrl: 0, e0: 0, e1: 0,  e2: 0,   len: 4096};

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = '0; stop = '0;
        repeat (3) @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset valid", int'(valid), 0);
        check("reset done", int'(done), 0);
        check("reset data", int'(data), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            nm = $sformatf("vec%0d", i);
            config_ch(tbl[i].ch, tbl[i].sf, tbl[i].sym, tbl[i].ctrl);
            mq.delete();
            model_reset();
            model_chirp(clamp_sf(tbl[i].sf), tbl[i].sym, tbl[i].ctrl[0]);
            start_pulse(1 << tbl[i].ch);
            check({nm, " busy after start"}, int'(busy[tbl[i].ch]), 1);
            check({nm, " no valid yet"}, int'(valid[tbl[i].ch]), 0);
            wait_idle(tbl[i].ch, tbl[i].len + 20, nm);
            @(negedge clk);
            verify(tbl[i].ch, nm, 1);
            check({nm, " length"}, rec_count(tbl[i].ch, 0), tbl[i].len);
            check({nm, " sample0"}, rec_data(tbl[i].ch, 0), tbl[i].e0);
            check({nm, " sample1"}, rec_data(tbl[i].ch, 1), tbl[i].e1);
            check({nm, " sample2"}, rec_data(tbl[i].ch, 2), tbl[i].e2);
        end

        cfg_write(8, 3);
        config_ch(0, 5, 0, 0);
        mq.delete(); model_reset(); model_chirp(5, 0, 0);
        start_pulse(1);
        wait_idle(0, 32 * 4 + 20, "div3");
        @(negedge clk);
        verify(0, "div3", 4);

        mq.delete();
        start_pulse(1);
        wait_valids(0, 8, 100, "divchg");
        cfg_write(8, 1);
        wait_idle(0, 32 * 4 + 20, "divchg");
        @(negedge clk);
        verify(0, "divchg", 0);
        gaps.delete(); bad = 0; prev = -1;
        foreach (mq[i]) if (mq[i].ch == 0) begin
            if (prev >= 0) gaps.push_back(mq[i].cyc - prev);
            prev = mq[i].cyc;
        end
        foreach (gaps[i]) if (gaps[i] < 2 || gaps[i] > 4) bad++;
        check("divchg gap out of range", bad, 0);
        check("divchg first gap", gaps.size() > 0 ? gaps[0] : -1, 4);
        check("divchg last gap", gaps.size() > 0 ? gaps[gaps.size()-1] : -1, 2);
        cfg_write(8, 0);

        config_ch(0, 5, 0, 2);
        mq.delete(); model_reset(); model_chirp(5, 0, 0); model_chirp(5, 5, 0);
        start_pulse(1);
        wait_valids(0, 10, 40, "repeat");
        cfg_write(1, 5);
        cfg_write(3, 0);
        wait_idle(0, 64 + 20, "repeat");
        @(negedge clk);
        verify(0, "repeat", 1);
        check("repeat done count", rec_count(0, 1), 2);

        config_ch(0, 5, 0, 0);
        mq.delete(); model_reset(); model_chirp(5, 0, 0);
        start_pulse(1);
        begin
            int cnt = 0, t = 0;
            while (cnt < 10 && t < 60) begin
                start[0] = (cnt == 5);
                @(negedge clk);
                if (valid[0]) cnt++;
                t++;
            end
            start = '0;
            check("stop reached sample 10", cnt, 10);
        end
        stop[0] = 1'b1;
        @(negedge clk);
        stop = '0;
        check("stop busy", int'(busy[0]), 0);
        check("stop valid", int'(valid[0]), 0);
        check("stop done", int'(done[0]), 0);
        check("stop data held", int'(data[7:0]), exp_d[9]);
        repeat (5) @(negedge clk);
        start[0] = 1'b1; stop[0] = 1'b1;
        @(negedge clk);
        start = '0; stop = '0;
        check("start+stop busy", int'(busy[0]), 0);
        repeat (3) @(negedge clk);
        check("stop sample count", rec_count(0, 0), 10);
        check("stop done count", rec_count(0, 1), 0);
        bad = 0;
        for (int i = 0; i < 10; i++) if (rec_data(0, i) != exp_d[i]) bad++;
        check("stop data mismatches", bad, 0);

        for (int it = 0; it < 6; it++) begin
            m = int'($urandom_range(1, 3));
            for (int c = 0; c < 2; c++) begin
                rsf[c]  = int'($urandom_range(0, 8));
                rsym[c] = int'($urandom_range(0, 65535));
                rdn[c]  = int'($urandom_range(0, 1));
                config_ch(c, rsf[c], rsym[c], rdn[c]);
            end
            mq.delete();
            start_pulse(m);
            wait_idle(0, 300, $sformatf("rnd%0d ch0", it));
            wait_idle(1, 300, $sformatf("rnd%0d ch1", it));
            @(negedge clk);
            for (int c = 0; c < 2; c++) begin
                model_reset();
                if (m[c]) model_chirp(clamp_sf(rsf[c]), rsym[c], rdn[c][0]);
                verify(c, $sformatf("rnd%0d ch%0d", it, c), m[c] ? 1 : 0);
            end
        end

        config_ch(0, 7, 9, 0);
        config_ch(1, 6, 1, 3);
        mq.delete();
        start_pulse(3);
        wait_valids(0, 5, 20, "rstmid");
        #2 rst = 1'b1;
        #1;
        check("rstmid busy", int'(busy), 0);
        check("rstmid valid", int'(valid), 0);
        check("rstmid done", int'(done), 0);
        check("rstmid data", int'(data), 0);
        @(negedge clk);
        rst = 1'b0;
        check("rstmid no done", rec_count(0, 1) + rec_count(1, 1), 0);
        @(negedge clk);
        mq.delete(); model_reset(); model_chirp(5, 0, 0);
        start_pulse(1);
        wait_idle(0, 60, "postrst");
        @(negedge clk);
        verify(0, "postrst", 1);

        check("done without valid", spur_done, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
